// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller that arbitrates IF fetches against MEM loads/stores.
// Optional feature: define MEMCTRL_RR_ARB_EN for round-robin arbitration (default: MEM beats IF).
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_IF_i,
  input  logic [31:0] addr_IF_i,
  output logic [31:0] inst_IF_o,
  output logic        done_IF_o,
  input  logic        req_MEM_i,
  input  logic        we_MEM_i,
  input  logic [1:0]  len_MEM_i,
  input  logic [31:0] addr_MEM_i,
  input  logic [31:0] wdata_MEM_i,
  output logic [31:0] rdata_MEM_o,
  output logic        done_MEM_o,
  output logic [31:0] addr_mem_o,
  input  logic [7:0]  d_mem_i,
  output logic [7:0]  d_mem_o,
  output logic        wr_mem_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, grant_owner;
  logic        grant_any, grant_write;
  logic [2:0]  grant_len;
  logic [31:0] grant_addr;

  logic [31:0] base_q, wdata_q, result_q, addr_q;
  logic [2:0]  nbytes_q;
  // READ: number of the next edge since grant; WRITE: index of the byte on the bus.
  logic [2:0]  cnt_q;

`ifdef MEMCTRL_RR_ARB_EN
  owner_t      last_q;
`endif

  assign grant_any = req_IF_i | req_MEM_i;

  // NOTE: every signal gets a default at the top of always_comb, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_owner = OWN_MEM;
`ifdef MEMCTRL_RR_ARB_EN
    if (req_MEM_i && req_IF_i)
      grant_owner = (last_q == OWN_MEM) ? OWN_IF : OWN_MEM;
    else if (req_IF_i)
      grant_owner = OWN_IF;
`else
    if (!req_MEM_i)
      grant_owner = OWN_IF;
`endif
  end

  always_comb begin
    grant_len   = 3'd4;
    grant_addr  = addr_IF_i;
    grant_write = 1'b0;
    if (grant_owner == OWN_MEM) begin
      grant_addr  = addr_MEM_i;
      grant_write = we_MEM_i;
      unique case (len_MEM_i)
        2'b00:   grant_len = 3'd1;
        2'b01:   grant_len = 3'd2;
        default: grant_len = 3'd4;
      endcase
    end
  end

  // Next state plus all Moore outputs; a stall freezes the state and kills the write strobe.
  always_comb begin
    state_d     = state_q;
    wr_mem_o    = 1'b0;
    d_mem_o     = 8'h00;
    done_IF_o   = 1'b0;
    done_MEM_o  = 1'b0;
    inst_IF_o   = 32'h0;
    rdata_MEM_o = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (rdy && grant_any)
          state_d = grant_write ? WRITE : READ;
      end
      READ: begin
        if (rdy && cnt_q == nbytes_q + 3'd1)
          state_d = DONE;
      end
      WRITE: begin
        wr_mem_o = rdy;
        unique case (cnt_q[1:0])
          2'd0:    d_mem_o = wdata_q[7:0];
          2'd1:    d_mem_o = wdata_q[15:8];
          2'd2:    d_mem_o = wdata_q[23:16];
          default: d_mem_o = wdata_q[31:24];
        endcase
        if (rdy && cnt_q == nbytes_q - 3'd1)
          state_d = DONE;
      end
      DONE: begin
        if (owner_q == OWN_IF) begin
          done_IF_o = 1'b1;
          inst_IF_o = result_q;
        end else begin
          done_MEM_o  = 1'b1;
          rdata_MEM_o = result_q;
        end
        if (rdy)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_IF;
      base_q   <= 32'h0;
      wdata_q  <= 32'h0;
      result_q <= 32'h0;
      addr_q   <= 32'h0;
      nbytes_q <= 3'd0;
      cnt_q    <= 3'd0;
`ifdef MEMCTRL_RR_ARB_EN
      last_q   <= OWN_IF;
`endif
    end else if (rdy) begin
      unique case (state_q)
        IDLE: begin
          if (grant_any) begin
            owner_q  <= grant_owner;
            base_q   <= grant_addr;
            wdata_q  <= wdata_MEM_i;
            nbytes_q <= grant_len;
            result_q <= 32'h0;
            addr_q   <= grant_addr;
            cnt_q    <= grant_write ? 3'd0 : 3'd1;
`ifdef MEMCTRL_RR_ARB_EN
            last_q   <= grant_owner;
`endif
          end
        end
        READ: begin
          if (cnt_q < nbytes_q)
            addr_q <= base_q + {29'd0, cnt_q};
          // RAM data lags the address by one cycle, so byte k lands at edge k+2.
          unique case (cnt_q)
            3'd2:    result_q[7:0]   <= d_mem_i;
            3'd3:    result_q[15:8]  <= d_mem_i;
            3'd4:    result_q[23:16] <= d_mem_i;
            3'd5:    result_q[31:24] <= d_mem_i;
            default: ;
          endcase
          cnt_q <= cnt_q + 3'd1;
        end
        WRITE: begin
          if (cnt_q != nbytes_q - 3'd1) begin
            cnt_q  <= cnt_q + 3'd1;
            addr_q <= base_q + {29'd0, cnt_q} + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign addr_mem_o = addr_q;

  a_done_onehot: assert property (@(posedge clk) !(done_IF_o && done_MEM_o));
  a_wr_in_write: assert property (@(posedge clk) wr_mem_o |-> (state_q == WRITE && rdy));

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized scoreboard bench for mem_ctrl with a byte-array RAM reference model.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        req_IF_i, req_MEM_i, we_MEM_i;
  logic [31:0] addr_IF_i, addr_MEM_i, wdata_MEM_i;
  logic [1:0]  len_MEM_i;
  logic [31:0] inst_IF_o, rdata_MEM_o, addr_mem_o;
  logic        done_IF_o, done_MEM_o, wr_mem_o;
  logic [7:0]  d_mem_i, d_mem_o;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_IF_i(req_IF_i), .addr_IF_i(addr_IF_i), .inst_IF_o(inst_IF_o), .done_IF_o(done_IF_o),
    .req_MEM_i(req_MEM_i), .we_MEM_i(we_MEM_i), .len_MEM_i(len_MEM_i), .addr_MEM_i(addr_MEM_i),
    .wdata_MEM_i(wdata_MEM_i), .rdata_MEM_o(rdata_MEM_o), .done_MEM_o(done_MEM_o),
    .addr_mem_o(addr_mem_o), .d_mem_i(d_mem_i), .d_mem_o(d_mem_o), .wr_mem_o(wr_mem_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
    int          issue;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] ram   [4096];
  logic [7:0] model [4096];
  exp_t exp_q[$];
  wr_t  wr_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
`ifdef MEMCTRL_RR_ARB_EN
  bit   last_mem = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: one-cycle read latency, gated by rdy like the real top level.
  always @(posedge clk) begin
    if (rdy) begin
      d_mem_i <= ram[addr_mem_o[11:0]];
      if (wr_mem_o) begin
        ram[addr_mem_o[11:0]] = d_mem_o;
        wr_log.push_back('{addr_mem_o, d_mem_o});
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic int nbytes(input bit is_if, input logic [1:0] len);
    if (is_if) return 4;
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  // Reference: a store writes its low bytes into the model, a load reads them back little-endian.
  function automatic logic [31:0] model_access(input bit is_if, input bit we, input logic [1:0] len,
                                               input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] r, ak, sh;
    r = 32'h0;
    for (int k = 0; k < nbytes(is_if, len); k++) begin
      ak = a + 32'(k);
      if (we && !is_if) begin
        sh = wd >> (8 * k);
        model[ak[11:0]] = sh[7:0];
      end else begin
        r = r | ({24'h0, model[ak[11:0]]} << (8 * k));
      end
    end
    return r;
  endfunction

  task automatic set_req(input bit is_if, input bit we, input logic [1:0] len,
                         input logic [31:0] a, input logic [31:0] wd);
    if (is_if) begin
      req_IF_i  = 1'b1;
      addr_IF_i = a;
    end else begin
      req_MEM_i   = 1'b1;
      we_MEM_i    = we;
      len_MEM_i   = len;
      addr_MEM_i  = a;
      wdata_MEM_i = wd;
    end
  endtask

  task automatic push_exp(input bit is_if, input bit we, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wd, input int extra, input bit chk_lat);
    exp_t e;
    int   n;
    n        = nbytes(is_if, len);
    e.is_if  = is_if;
    e.data   = model_access(is_if, we, len, a, wd);
    e.issue  = cyc;
    e.lat    = chk_lat ? (((we && !is_if) ? n : n + 1) + extra) : -1;
    exp_q.push_back(e);
`ifdef MEMCTRL_RR_ARB_EN
    last_mem = !is_if;
`endif
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done_IF_o || done_MEM_o) begin
      if (done_IF_o && done_MEM_o) begin
        fail_now("both done pulses");
      end else if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected done: IF=%0b MEM=%0b with nothing outstanding", done_IF_o, done_MEM_o);
      end else begin
        e = exp_q.pop_front();
        check("done owner is IF", {31'd0, done_IF_o}, {31'd0, e.is_if});
        if (done_IF_o) check("inst_IF_o", inst_IF_o, e.data);
        else           check("rdata_MEM_o", rdata_MEM_o, e.data);
        if (e.lat >= 0) check("latency", cyc - e.issue - 1, e.lat);
      end
    end
  end

  // One request from an idle controller; optional stall of stall_len edges after edge E(stall_after).
  task automatic do_req(input bit is_if, input bit we, input logic [1:0] len, input logic [31:0] a,
                        input logic [31:0] wd, input int stall_after, input int stall_len);
    logic [31:0] trace[$];
    logic [31:0] sh;
    int  n, hold_k;
    bit  st, got;
    n   = nbytes(is_if, len);
    st  = we && !is_if;
    got = 1'b0;
    wr_log.delete();
    set_req(is_if, we, len, a, wd);
    push_exp(is_if, we, len, a, wd, stall_len, 1'b1);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (is_if ? done_IF_o : done_MEM_o) begin
        got = 1'b1;
      end else begin
        trace.push_back(addr_mem_o);
        if (stall_len > 0 && trace.size() == stall_after + 1) begin
          hold_k = (stall_after < n) ? stall_after : n - 1;
          rdy = 1'b0;
          for (int s = 0; s < stall_len; s++) begin
            @(negedge clk);
            check("stall wr_mem_o", {31'd0, wr_mem_o}, 32'd0);
            check("stall addr_mem_o", addr_mem_o, a + 32'(hold_k));
          end
          rdy = 1'b1;
        end
      end
    end
    if (!got) fail_now("request done");
    if (is_if) req_IF_i = 1'b0;
    else       req_MEM_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (trace.size() > k) check("addr walk", trace[k], a + 32'(k));
      else                  fail_now("addr walk length");
    end
    check("write count", wr_log.size(), st ? n : 0);
    for (int k = 0; k < wr_log.size() && k < n; k++) begin
      sh = wd >> (8 * k);
      check("write addr", wr_log[k].a, a + 32'(k));
      check("write data", {24'h0, wr_log[k].d}, {24'h0, sh[7:0]});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // IF and MEM raised together and held until each sees its own done.
  task automatic do_pair(input logic [31:0] a_if, input bit we, input logic [1:0] len,
                         input logic [31:0] a_m, input logic [31:0] wd);
    bit mem_first;
`ifdef MEMCTRL_RR_ARB_EN
    mem_first = !last_mem;
`else
    mem_first = 1'b1;
`endif
    set_req(1'b1, 1'b0, 2'b10, a_if, 32'h0);
    set_req(1'b0, we, len, a_m, wd);
    if (mem_first) begin
      push_exp(1'b0, we, len, a_m, wd, 0, 1'b1);
      push_exp(1'b1, 1'b0, 2'b10, a_if, 32'h0, 0, 1'b0);
    end else begin
      push_exp(1'b1, 1'b0, 2'b10, a_if, 32'h0, 0, 1'b1);
      push_exp(1'b0, we, len, a_m, wd, 0, 1'b0);
    end
    for (int i = 0; i < 60 && (req_IF_i || req_MEM_i); i++) begin
      @(negedge clk);
      if (done_IF_o)  req_IF_i  = 1'b0;
      if (done_MEM_o) req_MEM_i = 1'b0;
    end
    if (req_IF_i || req_MEM_i) begin
      fail_now("pair done");
      req_IF_i  = 1'b0;
      req_MEM_i = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " addr_mem_o"}, addr_mem_o, 32'h0);
    check({tag, " wr_mem_o"}, {31'd0, wr_mem_o}, 32'h0);
    check({tag, " d_mem_o"}, {24'd0, d_mem_o}, 32'h0);
    check({tag, " done_IF_o"}, {31'd0, done_IF_o}, 32'h0);
    check({tag, " done_MEM_o"}, {31'd0, done_MEM_o}, 32'h0);
    check({tag, " inst_IF_o"}, inst_IF_o, 32'h0);
    check({tag, " rdata_MEM_o"}, rdata_MEM_o, 32'h0);
  endtask

  initial begin
    logic [7:0]  v;
    logic [31:0] a, wd;
    bit          is_if, we;
    logic [1:0]  len;
    int          n, sa, sl;

    for (int i = 0; i < 4096; i++) begin
      v        = 8'($urandom);
      ram[i]   = v;
      model[i] = v;
    end
    rst = 1'b1; rdy = 1'b1;
    req_IF_i = 1'b0; req_MEM_i = 1'b0; we_MEM_i = 1'b0; len_MEM_i = 2'b00;
    addr_IF_i = 32'h0; addr_MEM_i = 32'h0; wdata_MEM_i = 32'h0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Word fetch of 13 00 00 00 at 0x100.
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h00; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    model[12'h100] = 8'h13; model[12'h101] = 8'h00; model[12'h102] = 8'h00; model[12'h103] = 8'h00;
    do_req(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, -1, 0);

    // Halfword store must leave the third byte untouched.
    ram[12'h022] = 8'h5A; model[12'h022] = 8'h5A;
    do_req(1'b0, 1'b1, 2'b01, 32'h20, 32'hAABBCCDD, -1, 0);
    check("byte after halfword store", {24'h0, ram[12'h022]}, 32'h5A);
    do_req(1'b0, 1'b0, 2'b00, 32'h21, 32'h0, -1, 0);

    // Simultaneous requests, once after a MEM grant and once after an IF grant.
    do_pair(32'h100, 1'b0, 2'b00, 32'h20, 32'h0);
    do_req(1'b1, 1'b0, 2'b10, 32'h200, 32'h0, -1, 0);
    do_pair(32'h104, 1'b1, 2'b10, 32'h300, 32'h01020304);

    // Stalls in the middle of a fetch and of a store; wrap-around fetch.
    do_req(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 2, 3);
    do_req(1'b0, 1'b1, 2'b11, 32'h80, 32'hCAFEF00D, 1, 2);
    do_req(1'b1, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0, -1, 0);

    // Reset while the third byte of a word store is about to go out.
    wr_log.delete();
    set_req(1'b0, 1'b1, 2'b10, 32'h40, 32'h44332211);
    model[12'h040] = 8'h11;
    model[12'h041] = 8'h22;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_MEM_i = 1'b0;
`ifdef MEMCTRL_RR_ARB_EN
    last_mem = 1'b0;
`endif
    @(negedge clk);
    check_outputs_zero("mid-write reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("aborted write count", wr_log.size(), 32'd2);
    for (int k = 0; k < 4; k++)
      check("aborted write RAM byte", {24'h0, ram[12'h040 + 12'(k)]}, {24'h0, model[12'h040 + 12'(k)]});
    do_req(1'b0, 1'b0, 2'b10, 32'h40, 32'h0, -1, 0);

    // Randomized traffic with occasional stalls and wrap-around addresses.
    for (int t = 0; t < 60; t++) begin
      is_if = ($urandom_range(0, 2) == 0);
      we    = 1'($urandom);
      len   = 2'($urandom);
      wd    = $urandom;
      a     = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                          : 32'($urandom_range(0, 4095));
      n     = nbytes(is_if, len);
      sa    = -1;
      sl    = 0;
      if ($urandom_range(0, 3) == 0) begin
        sa = (we && !is_if) ? $urandom_range(0, n - 1) : $urandom_range(0, n);
        sl = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 4) == 0)
        do_pair(a, we, len, a ^ 32'h0000_0800, wd);
      else
        do_req(is_if, we, len, a, wd, sa, sl);
    end

    repeat (5) @(negedge clk);
    check("outstanding expectations", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-wide memory controller between the pipeline and the single 8-bit RAM port. It arbitrates between instruction fetch (IF) and data access (MEM) requests, and serialises each request into consecutive byte transactions. For reads it assembles little-endian bytes into a result word; for writes it splits the word into bytes. It answers each request with a one-cycle done pulse and is the only block that drives the RAM address, data and write-enable.

## Interface
- No parameters; RAM read latency is fixed at 1 cycle.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous and active-high.
- rdy  in  1  global ready; low = full stall.
- req_IF_i  in  1  fetch request; held high until done_IF_o.
- addr_IF_i  in  32  fetch byte address; always 4 bytes.
- inst_IF_o  out  32  fetched word; valid while done_IF_o=1.
- done_IF_o  out  1  one-cycle completion pulse for IF.
- req_MEM_i  in  1  data request; held high until done_MEM_o.
- we_MEM_i  in  1  1 = store, 0 = load.
- len_MEM_i  in  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
- addr_MEM_i  in  32  data byte address; no alignment check.
- wdata_MEM_i  in  32  store data; low len bytes are used.
- rdata_MEM_o  out  32  load result, zero-extended; valid while done_MEM_o=1.
- done_MEM_o  out  1  one-cycle completion pulse for MEM.
- addr_mem_o  out  32  RAM byte address.
- d_mem_i  in  8  RAM read data for the address presented in the previous cycle.
- d_mem_o  out  8  RAM write data.
- wr_mem_o  out  1  RAM write strobe, 1 = write.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - A pending request is sampled at edge E0 and granted; its address, length, data and owner are latched.
  - addr_mem_o = A from E0.
  - Next state is READ for a load or fetch, WRITE for a store.
- Arbitration: fixed priority, MEM over IF (see Configuration).
- READ for n bytes:
  - At edge Ek (k = 1..n-1), addr_mem_o = A+k.
  - At edge Ek (k = 2..n+1), byte k-2 is captured from d_mem_i into bits [8(k-2)+7 : 8(k-2)].
  - At E(n+1) the state becomes DONE.
- WRITE for n bytes:
  - During the cycle after Ek (k = 0..n-1), addr_mem_o = A+k, d_mem_o = wdata byte k and wr_mem_o = 1.
  - At En, wr_mem_o drops and the state becomes DONE.
- DONE:
  - Exactly one cycle with the owner's done pulse high.
  - Requests are ignored in DONE, so the requester has this edge to drop req.
  - The state then returns to IDLE.
- Result registers are cleared at grant, so unread upper bytes are 0.
- Outside WRITE, wr_mem_o = 0 and d_mem_o = 0. addr_mem_o holds its last value in IDLE and DONE.
- Address arithmetic is 32-bit modular: 0xFFFFFFFF + 1 wraps to 0.

## Timing
- Latency, counted from the grant edge E0 to the first cycle of the done pulse (after edge En):
  - Word fetch or load: 5 cycles.
  - Halfword load: 3 cycles.
  - Byte load: 2 cycles.
  - Word store: 4 cycles.
  - Byte store: 1 cycle.
- Back-to-back: the earliest next grant is 2 edges after the previous DONE state is entered.
- rdy = 0:
  - State, counters, addresses and results hold.
  - wr_mem_o is forced to 0.
  - The top level gates the RAM with rdy, so d_mem_i holds across the stall.
  - Operation resumes exactly where it stopped.
- A request changing its inputs before its done pulse is a protocol violation; the latched copies are used.
- Reset values (rst sampled high at any edge, including mid-transfer):
  - State goes to IDLE; all outputs are 0 from the next cycle.
  - An aborted transfer produces no done pulse.
  - A partially written word stays partially written.

## Configuration
- MEMCTRL_RR_ARB_EN undefined:
  - Fixed priority; MEM always wins over IF when both are pending at an IDLE edge.
- MEMCTRL_RR_ARB_EN defined:
  - One-bit last-grant register, reset to IF.
  - When both are pending, the requester not granted last wins.
  - A single pending requester always wins.

## Test plan
- IF word fetch, addr_IF_i = 0x100, RAM[0x100..0x103] = 13 00 00 00 -> done_IF_o high 5 cycles after grant, inst_IF_o = 0x00000013, addr_mem_o walks 0x100..0x103.
- MEM halfword store, addr = 0x20, wdata = 0xAABBCCDD -> two write cycles, (0x20, DD) then (0x21, CC); RAM[0x22] unchanged; done_MEM_o after 2 cycles.
- MEM byte load at 0x21 after the store above -> rdata_MEM_o = 0x000000CC, done after 2 cycles.
- IF and MEM raised on the same edge, both held -> MEM served first, IF second; with MEMCTRL_RR_ARB_EN defined and previous grant MEM, IF is served first.
- rdy low for 3 cycles in the middle of a word fetch -> wr_mem_o stays 0, outputs freeze, final word is correct, latency is 5 + 3 cycles.
- rst asserted during WRITE after byte 1 -> next cycle wr_mem_o = 0 and all outputs are 0, no done pulse, RAM holds bytes 0–1 only, next request served normally.
